// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-serial framed instruction-memory loader with core hold
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [7:0]  csum_q, csum_d;
    logic [23:0] word_q, word_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        accept;
    logic [15:0] new_len;
    logic [16:0] idx_next;

    assign in_ready  = (state_q != S_WRITE);
    assign accept    = in_valid && in_ready;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_hold = (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERROR);
    assign busy      = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_WRITE)  ||
                       (state_q == S_CSUM);
    assign new_len   = {in_data, len_q[7:0]};
    // 17-bit compare so a 16-bit length is never truncated against the index
    assign idx_next  = {1'b0, idx_q} + 17'd1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        bcnt_d      = bcnt_q;
        csum_d      = csum_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_SYNC, S_DONE, S_ERROR: begin
                if (accept && in_data == SYNC_BYTE) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d  = new_len;
                    idx_d  = 16'd0;
                    bcnt_d = 2'd0;
                    csum_d = 8'd0;
                    if (new_len == 16'd0 || {1'b0, new_len} > MAX_LEN) state_d = S_ERROR;
                    else state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: word_d[7:0]   = in_data;
                        2'd1: word_d[15:8]  = in_data;
                        2'd2: word_d[23:16] = in_data;
                        default: begin
                            // Write strobe is registered, so it lands in the WRITE cycle
                            mem_we_d    = 1'b1;
                            mem_wdata_d = {in_data, word_q};
                            mem_addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                            state_d     = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                idx_d  = idx_q + 16'd1;
                bcnt_d = 2'd0;
                if (idx_next == {1'b0, len_q}) state_d = S_CSUM;
                else state_d = S_DATA;
            end
            S_CSUM: begin
                if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_SYNC;
            len_q       <= 16'd0;
            idx_q       <= 16'd0;
            bcnt_q      <= 2'd0;
            csum_q      <= 8'd0;
            word_q      <= 24'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            bcnt_q      <= bcnt_d;
            csum_q      <= csum_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven frame bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_we, core_hold, busy, done, err;
    logic [31:0] mem_addr, mem_wdata;

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_hold(core_hold), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           n;
        logic [127:0] bytes;
        logic         gaps;
        int           nwr;
        logic [31:0]  fa, fd, la, ld;
        logic         done, err;
    } vec_t;

    vec_t        vecs [0:7];
    int          total = 0;
    int          bad = 0;
    int          wr_cnt = 0;
    int          rdy_low = 0;
    logic [31:0] wa [0:255];
    logic [31:0] wd [0:255];

    always @(negedge clk) begin
        if (mem_we) begin
            wa[wr_cnt % 256] = mem_addr;
            wd[wr_cnt % 256] = mem_wdata;
            wr_cnt = wr_cnt + 1;
        end
        if (rst_n && !in_ready) rdy_low = rdy_low + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic gaps);
        int g;
        int t;
        g = gaps ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic apply_vec(input int v);
        int w0;
        int r0;
        w0 = wr_cnt;
        r0 = rdy_low;
        for (int i = 0; i < vecs[v].n; i++)
            send(vecs[v].bytes[127 - 8 * i -: 8], vecs[v].gaps);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_nwr", v), wr_cnt - w0, vecs[v].nwr);
        chk($sformatf("v%0d_ready_low", v), rdy_low - r0, vecs[v].nwr);
        if (vecs[v].nwr > 0) begin
            chk($sformatf("v%0d_first_addr", v), wa[w0 % 256], vecs[v].fa);
            chk($sformatf("v%0d_first_data", v), wd[w0 % 256], vecs[v].fd);
            chk($sformatf("v%0d_last_addr", v), wa[(wr_cnt - 1) % 256], vecs[v].la);
            chk($sformatf("v%0d_last_data", v), wd[(wr_cnt - 1) % 256], vecs[v].ld);
        end
        chk($sformatf("v%0d_done", v), {31'd0, done}, {31'd0, vecs[v].done});
        chk($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, vecs[v].err});
        chk($sformatf("v%0d_hold", v), {31'd0, core_hold}, {31'd0, ~vecs[v].done});
        chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int w;
        vecs[0] = '{12, {8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h63, 8'h14, 8'hB5, 8'h00, 8'hC4, 32'h0},
                    1'b0, 2, 32'h0, 32'h0010_0513, 32'h4, 32'h00B5_1463, 1'b1, 1'b0};
        vecs[1] = '{12, {8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h63, 8'h14, 8'hB5, 8'h00, 8'hC5, 32'h0},
                    1'b0, 2, 32'h0, 32'h0010_0513, 32'h4, 32'h00B5_1463, 1'b0, 1'b1};
        vecs[2] = '{3, {24'hA5_0000, 104'h0}, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[3] = '{3, {24'hA5_4100, 104'h0}, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[4] = '{8, {8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22, 64'h0},
                    1'b0, 1, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[5] = '{10, {8'h00, 8'h11, 8'hA5, 8'h01, 8'h00, 8'h78, 8'hA5, 8'h34, 8'h12, 8'hFB, 48'h0},
                    1'b0, 1, 32'h0, 32'h1234_A578, 32'h0, 32'h1234_A578, 1'b1, 1'b0};
        vecs[6] = '{16, {8'hA5, 8'h03, 8'h00, 32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 8'h0C},
                    1'b1, 3, 32'h0, 32'h0403_0201, 32'h8, 32'h0C0B_0A09, 1'b1, 1'b0};
        vecs[7] = vecs[6];
        vecs[7].gaps = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_hold_busy_done_err", {28'd0, core_hold, busy, done, err}, 32'b1000);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) apply_vec(v);

        send(8'hA5, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("reload_hold_done_busy", {29'd0, core_hold, done, busy}, 32'b101);

        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        w = wr_cnt;
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
        send(8'h44, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_word0_write", wr_cnt - w, 32'd1);
        chk("mid_word0_data", wd[w % 256], 32'h4433_2211);
        rst_n = 1'b0;
        w = wr_cnt;
        @(negedge clk);
        chk("midrst_outputs", {in_ready, mem_we, core_hold, busy, done, err, 26'd0}, {6'b101000, 26'd0});
        chk("midrst_addr", mem_addr, 32'h0);
        chk("midrst_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_no_stray_write", wr_cnt - w, 32'd0);
        apply_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
